// File: rtl/mcycle_pkg.sv
// ============================================================================
//  Module   : mcycle_pkg
//  Purpose  : Shared encodings for the multi-cycle MIPS-style controller:
//             FSM states, ALU operation codes, opcode/funct constants, mux
//             select encodings and the instruction-class bundle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcycle_pkg;

  // FSM state encoding (also driven out on the state port)
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instruction bits [5:0])
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // pcSrc select
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  // aluSrcB select
  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  // regDst select
  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  // memToReg select
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // One-hot instruction class; exactly one bit is set for any opcode/funct
  typedef struct packed {
    logic r_add;
    logic r_sub;
    logic r_slt;
    logic r_jr;
    logic lw;
    logic sw;
    logic j;
    logic jal;
    logic beq;
    logic bne;
    logic addi;
    logic xori;
    logic illegal;
  } iclass_t;

  // ALU operation for the arithmetic R-type instructions
  function automatic logic [2:0] rtype_aluop(input iclass_t cls);
    if (cls.r_sub)      return ALU_SUB;
    else if (cls.r_slt) return ALU_SLT;
    else                return ALU_ADD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mcycle_opclass.sv
// ============================================================================
//  Module   : mcycle_opclass
//  Purpose  : Combinational decoder turning opcode/funct into a one-hot
//             instruction-class bundle for the control FSM. Anything not
//             recognised lands in the illegal class.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcycle_opclass
  import mcycle_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  // Opcode first, then funct for the R-type group
  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  cls.r_add   = 1'b1;
          FN_SUB:  cls.r_sub   = 1'b1;
          FN_SLT:  cls.r_slt   = 1'b1;
          FN_JR:   cls.r_jr    = 1'b1;
          default: cls.illegal = 1'b1;
        endcase
      end
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_J:    cls.j       = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_BNE:  cls.bne     = 1'b1;
      OP_ADDI: cls.addi    = 1'b1;
      OP_XORI: cls.xori    = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mcycle_ctrl.sv
// ============================================================================
//  Module   : mcycle_ctrl
//  Purpose  : Multi-cycle datapath controller (FETCH/DECODE/EXEC/MEM/WB)
//             with a memory wait-timeout watchdog (sticky memErr).
//  Config   : MCYCLE_TRAP_EN - when defined, illegal instructions enter a
//             TRAP state that holds trap=1 until reset; otherwise they
//             retire as a NOP from DECODE and trap stays 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcycle_ctrl
  import mcycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memReady,
  output logic       irWrEn,
  output logic       pcWrEn,
  output logic       memRd,
  output logic       memWr,
  output logic       iorD,
  output logic       regWrEn,
  output logic       aluSrcA,
  output logic [1:0] pcSrc,
  output logic [1:0] aluSrcB,
  output logic [1:0] regDst,
  output logic [1:0] memToReg,
  output logic [2:0] aluOp,
  output logic [2:0] state,
  output logic       instrDone,
  output logic       memErr,
  output logic       trap
);

  localparam int                CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  iclass_t           cls;
  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  wait_cnt;
  logic              is_rtype;
  logic              waiting;

  mcycle_opclass u_opclass (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  assign is_rtype = cls.r_add | cls.r_sub | cls.r_slt;
  assign waiting  = ((state_q == S_FETCH) || (state_q == S_MEM)) && !memReady;
  assign state    = state_q;

  // Control outputs and next state; reset blanks every output so FETCH
  // decoding cannot leak a memory request or write enable while held
  always_comb begin
    irWrEn    = 1'b0;
    pcWrEn    = 1'b0;
    memRd     = 1'b0;
    memWr     = 1'b0;
    iorD      = 1'b0;
    regWrEn   = 1'b0;
    aluSrcA   = 1'b0;
    pcSrc     = PC_SRC_ALU;
    aluSrcB   = SRCB_REG;
    regDst    = DST_RT;
    memToReg  = M2R_ALUOUT;
    aluOp     = ALU_ADD;
    instrDone = 1'b0;
    trap      = 1'b0;
    state_d   = state_q;

    case (state_q)
      S_FETCH: begin
        memRd   = 1'b1;
        aluSrcB = SRCB_FOUR;
        if (memReady) begin
          irWrEn  = 1'b1;
          pcWrEn  = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target is computed here speculatively into ALUOut
        aluSrcB = SRCB_IMM_SH2;
        if (cls.j || cls.jal) begin
          pcWrEn    = 1'b1;
          pcSrc     = PC_SRC_JUMP;
          instrDone = 1'b1;
          state_d   = S_FETCH;
          if (cls.jal) begin
            regWrEn  = 1'b1;
            regDst   = DST_R31;
            memToReg = M2R_PC;
          end
        end else if (cls.r_jr) begin
          pcWrEn    = 1'b1;
          pcSrc     = PC_SRC_RS;
          instrDone = 1'b1;
          state_d   = S_FETCH;
        end else if (cls.illegal) begin
`ifdef MCYCLE_TRAP_EN
          state_d   = S_TRAP;
`else
          instrDone = 1'b1;
          state_d   = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        aluSrcA = 1'b1;
        if (is_rtype) begin
          aluSrcB = SRCB_REG;
          aluOp   = rtype_aluop(cls);
          state_d = S_WB;
        end else if (cls.addi || cls.xori) begin
          aluSrcB = SRCB_IMM;
          aluOp   = cls.xori ? ALU_XOR : ALU_ADD;
          state_d = S_WB;
        end else if (cls.lw || cls.sw) begin
          aluSrcB = SRCB_IMM;
          state_d = S_MEM;
        end else if (cls.beq || cls.bne) begin
          aluSrcB   = SRCB_REG;
          aluOp     = ALU_SUB;
          pcSrc     = PC_SRC_ALUOUT;
          pcWrEn    = cls.beq ? zero : !zero;
          instrDone = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        iorD  = 1'b1;
        memRd = cls.lw;
        memWr = cls.sw;
        if (memReady) begin
          if (cls.lw) begin
            state_d = S_WB;
          end else begin
            instrDone = 1'b1;
            state_d   = S_FETCH;
          end
        end else if (!(cls.lw || cls.sw)) begin
          state_d = S_FETCH;
        end
      end

      S_WB: begin
        regWrEn   = 1'b1;
        instrDone = 1'b1;
        regDst    = is_rtype ? DST_RD : DST_RT;
        memToReg  = cls.lw ? M2R_MDR : M2R_ALUOUT;
        state_d   = S_FETCH;
      end

      S_TRAP: begin
`ifdef MCYCLE_TRAP_EN
        trap    = 1'b1;
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end

      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      irWrEn    = 1'b0;
      pcWrEn    = 1'b0;
      memRd     = 1'b0;
      memWr     = 1'b0;
      iorD      = 1'b0;
      regWrEn   = 1'b0;
      aluSrcA   = 1'b0;
      pcSrc     = PC_SRC_ALU;
      aluSrcB   = SRCB_REG;
      regDst    = DST_RT;
      memToReg  = M2R_ALUOUT;
      aluOp     = ALU_ADD;
      instrDone = 1'b0;
      trap      = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory wait watchdog: counts consecutive not-ready cycles in one state,
  // saturates at the last count and latches memErr until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      memErr   <= 1'b0;
    end else if (!waiting || (state_d != state_q)) begin
      wait_cnt <= '0;
    end else if (wait_cnt == CNT_LAST) begin
      memErr <= 1'b1;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning the number of memReady-wait cycles before memErr is raised.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port opcode, input, 6 bits: instruction register bits [31:26].
REQ-005 SHALL have port funct, input, 6 bits: instruction register bits [5:0].
REQ-006 SHALL have port zero, input, 1 bit: ALU result-equals-zero flag.
REQ-007 SHALL have port memReady, input, 1 bit: the memory completes the current access this cycle.
REQ-008 SHALL have outputs irWrEn, pcWrEn, memRd, memWr, iorD, regWrEn and aluSrcA, each 1 bit.
REQ-009 SHALL have outputs pcSrc, aluSrcB, regDst and memToReg, each 2 bits.
REQ-010 SHALL have output aluOp, 3 bits: ADD=0, SUB=1, XOR=2, SLT=3.
REQ-011 SHALL have output state, 3 bits: the current FSM state.
REQ-012 SHALL have output instrDone, 1 bit: a one-cycle pulse on the final cycle of each instruction.
REQ-013 SHALL have output memErr, 1 bit: sticky memory-timeout flag.
REQ-014 SHALL have output trap, 1 bit: illegal-instruction flag; see Configuration.

Function
REQ-015 SHALL decode lw 23h, sw 2Bh, j 02h, jal 03h, beq 04h, bne 05h, addi 08h and xori 0Eh by opcode; with opcode 00h, SHALL decode add funct 20h, sub 22h, slt 2Ah and jr 08h.
REQ-016 SHALL have FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5.
REQ-017 FETCH: memRd=1, iorD=0, aluSrcA=0, aluSrcB=1 (constant 4), aluOp=ADD.
- Stays in FETCH while memReady=0.
- On memReady=1: irWrEn=1, pcWrEn=1, pcSrc=0; next state DECODE.
REQ-018 DECODE: aluSrcA=0, aluSrcB=3 (sign-extended imm<<2), aluOp=ADD, so the branch target is latched into ALUOut.
REQ-019 DECODE, j: pcWrEn=1, pcSrc=2 (jump target), instrDone=1; next state FETCH.
REQ-020 DECODE, jal: as j, plus regWrEn=1, regDst=2 (r31), memToReg=2 (PC); next state FETCH.
REQ-021 DECODE, jr: pcWrEn=1, pcSrc=3 (rs), instrDone=1; next state FETCH. All other legal instructions go to EXEC.
REQ-022 EXEC:
- R-type: aluSrcA=1, aluSrcB=0, aluOp from funct; next state WB.
- addi/xori: aluSrcA=1, aluSrcB=2, aluOp ADD/XOR; next state WB.
- lw/sw: aluSrcA=1, aluSrcB=2, aluOp=ADD; next state MEM.
REQ-023 EXEC, beq/bne: aluSrcA=1, aluSrcB=0, aluOp=SUB, pcSrc=1.
- pcWrEn=zero for beq; pcWrEn=!zero for bne.
- instrDone=1; next state FETCH.
REQ-024 MEM: iorD=1; memRd=1 for lw, memWr=1 for sw; holds the request until memReady=1.
- On memReady=1, lw goes to WB.
- On memReady=1, sw pulses instrDone and goes to FETCH.
REQ-025 WB: regWrEn=1, instrDone=1; next state FETCH.
- regDst=1 (rd) for R-type; regDst=0 (rt) for lw/addi/xori.
- memToReg=1 (MDR) for lw; memToReg=0 (ALUOut) otherwise.
REQ-026 Outputs not named for a state SHALL be 0 in that state.
REQ-027 Outputs SHALL be combinational from state, opcode, funct, zero and memReady.
REQ-028 SHALL run a wait counter while in FETCH or MEM with memReady=0.
- The counter clears on memReady=1 or on any state change.
- When the count reaches MEM_TIMEOUT-1 with memReady still 0, memErr SHALL set and stay set until reset.
- The FSM keeps waiting after memErr sets.
REQ-029 Instruction latency SHALL be:
- j/jal/jr: 2 cycles.
- beq/bne: 3 cycles.
- R-type/addi/xori: 4 cycles.
- sw: 4 cycles.
- lw: 5 cycles.
- Each extra memReady=0 cycle adds one cycle to these counts.

Reset
REQ-030 While reset=1, SHALL force state=FETCH, wait counter=0, memErr=0 and trap=0.
REQ-031 While reset=1, all enables and request outputs SHALL be 0, overriding FETCH decoding.
REQ-032 Reset asserted mid-instruction SHALL abort the instruction immediately, with no write enable pulsed.
REQ-033 The first cycle after reset release SHALL be FETCH.

Configuration
REQ-034 Macro MCYCLE_TRAP_EN SHALL control illegal-instruction handling.
- Defined: an unlisted opcode/funct in DECODE goes to TRAP; TRAP holds trap=1 and all enables 0 until reset.
- Undefined: an unlisted instruction is a NOP; DECODE pulses instrDone and goes to FETCH; trap is tied to 0; the TRAP state is unreachable.

Structure
REQ-035 Package mcycle_pkg SHALL hold the state encoding, aluOp codes, opcode/funct constants and the pcSrc/aluSrcB/regDst/memToReg encodings.
REQ-036 A combinational sub-module mcycle_opclass SHALL classify opcode/funct into one-hot instruction-class signals consumed by the FSM.

Verification
REQ-037 add (opcode 00h, funct 20h) with memReady=1 -> states 0,1,2,4; regWrEn=1, regDst=1, aluOp=0 at WB; instrDone on cycle 4.
REQ-038 lw with memReady low for 3 cycles in MEM -> MEM lasts 4 cycles with memRd=1, iorD=1; WB has memToReg=1, regDst=0; total latency 8 cycles.
REQ-039 beq with zero=0, then bne with zero=0 -> pcWrEn=0 for beq and pcWrEn=1, pcSrc=1 for bne, both in EXEC.
REQ-040 jal -> DECODE asserts regWrEn=1, regDst=2, memToReg=2, pcWrEn=1, pcSrc=2; back in FETCH next cycle.
REQ-041 memReady held 0 in FETCH with MEM_TIMEOUT=16 -> memErr rises after 16 wait cycles; reset pulse clears it and returns to FETCH with all enables 0.
REQ-042 opcode 3Fh -> with MCYCLE_TRAP_EN: state=5 and trap=1 held; without it: instrDone pulse in DECODE, then FETCH.
